// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if -- bundle of every signal between the two-requester memory
// arbiter, its requesters and the data memory (DM).
//
//   m0_*/m1_*  requester side: req/addr/wdata/we/mem_op in, gnt/rvalid/rdata/err out
//   dm_*       DM side: addr/wdata/we/mem_op out, rdata/adel/ades in
//   busy       arbiter is in the middle of a transaction
//
// Modports:
//   slave  -- the arbiter's view
//   master -- the environment's view (requesters plus DM model)
interface mem_arbiter_if;
    logic        m0_req;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic        m0_we;
    logic [2:0]  m0_mem_op;
    logic        m0_gnt;
    logic        m0_rvalid;
    logic [31:0] m0_rdata;
    logic        m0_err;

    logic        m1_req;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic        m1_we;
    logic [2:0]  m1_mem_op;
    logic        m1_gnt;
    logic        m1_rvalid;
    logic [31:0] m1_rdata;
    logic        m1_err;

    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_we;
    logic [2:0]  dm_mem_op;
    logic [31:0] dm_rdata;
    logic        dm_adel;
    logic        dm_ades;
    logic        busy;

    modport slave (
        input  m0_req, m0_addr, m0_wdata, m0_we, m0_mem_op,
        output m0_gnt, m0_rvalid, m0_rdata, m0_err,
        input  m1_req, m1_addr, m1_wdata, m1_we, m1_mem_op,
        output m1_gnt, m1_rvalid, m1_rdata, m1_err,
        output dm_addr, dm_wdata, dm_we, dm_mem_op,
        input  dm_rdata, dm_adel, dm_ades,
        output busy
    );

    modport master (
        output m0_req, m0_addr, m0_wdata, m0_we, m0_mem_op,
        input  m0_gnt, m0_rvalid, m0_rdata, m0_err,
        output m1_req, m1_addr, m1_wdata, m1_we, m1_mem_op,
        input  m1_gnt, m1_rvalid, m1_rdata, m1_err,
        input  dm_addr, dm_wdata, dm_we, dm_mem_op,
        output dm_rdata, dm_adel, dm_ades,
        input  busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter -- shares one data memory between two requesters.
//
// A transaction takes three cycles: grant (IDLE), DM access (ACCESS) and a
// one-cycle response pulse (RESP). Grant is combinational in IDLE; the
// winner's request fields are latched on the grant edge so the requester is
// free to change them afterwards.
//
// Ports:
//   clk  -- clock, rising edge
//   rst  -- synchronous active-high reset; aborts any transaction in flight
//   bus  -- mem_arbiter_if.slave (requesters m0/m1, DM port, busy)
//
// Build option:
//   MEM_ARBITER_RR_EN  defined   -> round-robin tie-break via last_winner
//                      undefined -> fixed priority, m0 wins ties
module mem_arbiter (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t             state;
    logic [1:0]         req;
    logic [1:0]         gnt;
    logic [1:0][31:0]   addr;
    logic [1:0][31:0]   wdata;
    logic [1:0]         we;
    logic [1:0][2:0]    mem_op;
    logic               winner;

    logic [31:0]        lat_addr;
    logic [31:0]        lat_wdata;
    logic               lat_we;
    logic [2:0]         lat_op;
    logic               lat_id;

    logic [1:0][31:0]   rdata_q;
    logic [1:0]         err_q;
    logic [1:0]         rvalid_q;
    logic               in_access;

    assign req    = {bus.m1_req,    bus.m0_req};
    assign addr   = {bus.m1_addr,   bus.m0_addr};
    assign wdata  = {bus.m1_wdata,  bus.m0_wdata};
    assign we     = {bus.m1_we,     bus.m0_we};
    assign mem_op = {bus.m1_mem_op, bus.m0_mem_op};

`ifdef MEM_ARBITER_RR_EN
    logic last_winner;

    // On a tie the requester that did not win last time goes next.
    always_comb begin
        if (&req) winner = ~last_winner;
        else      winner = ~req[0];
    end
`else
    // m0 wins whenever it asks.
    assign winner = ~req[0];
`endif

    // Held off during reset so nothing is accepted on a reset edge.
    assign gnt[0] = (state == IDLE) && !rst && req[0] && !winner;
    assign gnt[1] = (state == IDLE) && !rst && req[1] &&  winner;

    // DM port is quiet outside ACCESS, and dm_we drops in the reset cycle
    // so an aborted store never reaches memory.
    assign in_access     = (state == ACCESS) && !rst;
    assign bus.dm_addr   = in_access ? lat_addr  : '0;
    assign bus.dm_wdata  = in_access ? lat_wdata : '0;
    assign bus.dm_mem_op = in_access ? lat_op    : '0;
    assign bus.dm_we     = in_access && lat_we && !bus.dm_ades;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_we    <= 1'b0;
            lat_op    <= '0;
            lat_id    <= 1'b0;
            rdata_q   <= '0;
            err_q     <= '0;
            rvalid_q  <= '0;
`ifdef MEM_ARBITER_RR_EN
            last_winner <= 1'b1;
`endif
        end else begin
            rvalid_q <= '0;
            case (state)
                IDLE: begin
                    if (|gnt) begin
                        lat_addr  <= addr[winner];
                        lat_wdata <= wdata[winner];
                        lat_we    <= we[winner];
                        lat_op    <= mem_op[winner];
                        lat_id    <= winner;
                        state     <= ACCESS;
`ifdef MEM_ARBITER_RR_EN
                        last_winner <= winner;
`endif
                    end
                end
                ACCESS: begin
                    // Stores report zero data; the fault bit follows direction.
                    rdata_q[lat_id]  <= lat_we ? 32'd0 : bus.dm_rdata;
                    err_q[lat_id]    <= lat_we ? bus.dm_ades : bus.dm_adel;
                    rvalid_q[lat_id] <= 1'b1;
                    state            <= RESP;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.m0_gnt    = gnt[0];
    assign bus.m1_gnt    = gnt[1];
    assign bus.m0_rvalid = rvalid_q[0];
    assign bus.m1_rvalid = rvalid_q[1];
    assign bus.m0_rdata  = rdata_q[0];
    assign bus.m1_rdata  = rdata_q[1];
    assign bus.m0_err    = err_q[0];
    assign bus.m1_err    = err_q[1];
    assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter -- bench for mem_arbiter. A DM model serves the DM port;
// two queue-fed requester drivers hold req until granted. A predictor checks
// grants and the DM port each cycle and pushes expected responses; a
// separate monitor pops them when rvalid pulses.
`timescale 1ns/1ps
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if bus();
    mem_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic [2:0]  op;
    } cmd_t;

    typedef struct {
        bit          id;
        logic [31:0] rdata;
        bit          err;
        int          due;
    } exp_t;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    cmd_t q0[$];
    cmd_t q1[$];
    exp_t sb[$];
    bit   gnt_log[$];
    logic [1:0] g_seen = 2'b00;

    logic [31:0] dm_mem  [0:255];
    logic [31:0] ref_mem [0:255];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // op[1:0]: 0 byte, 1 half, 2/3 word
    function automatic logic misaligned(input logic [31:0] a, input logic [2:0] op);
        case (op[1:0])
            2'd0:    return 1'b0;
            2'd1:    return a[0];
            default: return a[1:0] != 2'b00;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] a,
                                          input logic [31:0] d, input logic [2:0] op);
        logic [31:0] r;
        r = old;
        case (op[1:0])
            2'd0:    r[8*a[1:0] +: 8] = d[7:0];
            2'd1:    r[16*a[1] +: 16] = d[15:0];
            default: r = d;
        endcase
        return r;
    endfunction

    // ---------------- DM model ----------------
    assign bus.dm_rdata = dm_mem[bus.dm_addr[9:2]];
    assign bus.dm_adel  = misaligned(bus.dm_addr, bus.dm_mem_op);
    assign bus.dm_ades  = misaligned(bus.dm_addr, bus.dm_mem_op);
    always @(posedge clk)
        if (bus.dm_we)
            dm_mem[bus.dm_addr[9:2]] <= merge(dm_mem[bus.dm_addr[9:2]], bus.dm_addr, bus.dm_wdata, bus.dm_mem_op);

    always @(posedge clk) cyc = cyc + 1;
    always @(negedge clk) g_seen = {bus.m1_gnt, bus.m0_gnt};

    // ---------------- requester drivers ----------------
    initial begin
        cmd_t c;
        bus.m0_req = 0; bus.m0_addr = 0; bus.m0_wdata = 0; bus.m0_we = 0; bus.m0_mem_op = 0;
        forever begin
            @(posedge clk); #1;
            if (bus.m0_req && g_seen[0]) begin
                bus.m0_req = 0; bus.m0_addr = $urandom; bus.m0_wdata = $urandom;
            end
            #1;
            if (!bus.m0_req && q0.size() > 0) begin
                c = q0.pop_front();
                bus.m0_addr = c.addr; bus.m0_wdata = c.wdata; bus.m0_we = c.we;
                bus.m0_mem_op = c.op; bus.m0_req = 1;
            end
        end
    end

    initial begin
        cmd_t c;
        bus.m1_req = 0; bus.m1_addr = 0; bus.m1_wdata = 0; bus.m1_we = 0; bus.m1_mem_op = 0;
        forever begin
            @(posedge clk); #1;
            if (bus.m1_req && g_seen[1]) begin
                bus.m1_req = 0; bus.m1_addr = $urandom; bus.m1_wdata = $urandom;
            end
            #1;
            if (!bus.m1_req && q1.size() > 0) begin
                c = q1.pop_front();
                bus.m1_addr = c.addr; bus.m1_wdata = c.wdata; bus.m1_we = c.we;
                bus.m1_mem_op = c.op; bus.m1_req = 1;
            end
        end
    end

    // ---------------- predictor ----------------
    int   next_free = 0;
    int   last_gnt = -10;
    int   acc_cyc = -10;
    bit   last_w = 1'b1;
    cmd_t m_cmd;
    bit   m_mis;

    always @(negedge clk) begin
        logic [1:0] r, ag, eg;
        bit w;
        exp_t e;
        r  = {bus.m1_req, bus.m0_req};
        ag = {bus.m1_gnt, bus.m0_gnt};
        if (rst) begin
            check("rst_gnt", ag, 2'b00);
            check("rst_dm_we", bus.dm_we, 1'b0);
            next_free = cyc + 1; last_gnt = -10; acc_cyc = -10; last_w = 1'b1;
            sb.delete();
        end else begin
            eg = 2'b00;
            w  = 1'b0;
            if (cyc >= next_free && r != 2'b00) begin
`ifdef MEM_ARBITER_RR_EN
                w = (r == 2'b11) ? !last_w : (r == 2'b10);
`else
                w = (r == 2'b10);
`endif
                eg = w ? 2'b10 : 2'b01;
            end
            check("gnt", ag, eg);
            if (ag != 2'b00) gnt_log.push_back(ag[1]);
            if (eg != 2'b00) begin
                last_w = w;
                m_cmd.addr  = w ? bus.m1_addr   : bus.m0_addr;
                m_cmd.wdata = w ? bus.m1_wdata  : bus.m0_wdata;
                m_cmd.we    = w ? bus.m1_we     : bus.m0_we;
                m_cmd.op    = w ? bus.m1_mem_op : bus.m0_mem_op;
                m_mis       = misaligned(m_cmd.addr, m_cmd.op);
                acc_cyc = cyc + 1; last_gnt = cyc; next_free = cyc + 3;
                e.id    = w;
                e.rdata = m_cmd.we ? 32'd0 : ref_mem[m_cmd.addr[9:2]];
                e.err   = m_mis;
                e.due   = cyc + 2;
                sb.push_back(e);
            end
            check("busy", bus.busy, (cyc > last_gnt) && (cyc < next_free));
            if (cyc == acc_cyc) begin
                check("dm_addr",   bus.dm_addr,   m_cmd.addr);
                check("dm_wdata",  bus.dm_wdata,  m_cmd.wdata);
                check("dm_mem_op", bus.dm_mem_op, m_cmd.op);
                check("dm_we",     bus.dm_we,     m_cmd.we && !m_mis);
                if (m_cmd.we && !m_mis)
                    ref_mem[m_cmd.addr[9:2]] = merge(ref_mem[m_cmd.addr[9:2]], m_cmd.addr, m_cmd.wdata, m_cmd.op);
            end else begin
                check("dm_idle", {bus.dm_addr, bus.dm_wdata, bus.dm_we, bus.dm_mem_op}, '0);
            end
        end
    end

    // ---------------- response monitor ----------------
    logic [31:0] hold_rd [2];
    bit          hold_err [2];

    always @(negedge clk) begin
        logic [1:0] rv;
        exp_t e;
        bit id;
        if (rst) begin
            hold_rd[0] = 0; hold_rd[1] = 0; hold_err[0] = 0; hold_err[1] = 0;
        end else begin
            rv = {bus.m1_rvalid, bus.m0_rvalid};
            if (rv != 2'b00) begin
                check("rvalid_onehot", $countones(rv), 1);
                if (sb.size() == 0) begin
                    check("rvalid_unexpected", rv, 2'b00);
                end else begin
                    e  = sb.pop_front();
                    id = rv[1];
                    check("rsp_id", id, e.id);
                    check("rsp_cycle", cyc, e.due);
                    check("rsp_rdata", id ? bus.m1_rdata : bus.m0_rdata, e.rdata);
                    check("rsp_err", id ? bus.m1_err : bus.m0_err, e.err);
                    hold_rd[e.id] = e.rdata; hold_err[e.id] = e.err;
                end
            end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                check("rsp_missing", 1'b0, 1'b1);
                void'(sb.pop_front());
            end
            check("hold_m0", {bus.m0_err, bus.m0_rdata}, {hold_err[0], hold_rd[0]});
            check("hold_m1", {bus.m1_err, bus.m1_rdata}, {hold_err[1], hold_rd[1]});
        end
    end

    // ---------------- helpers ----------------
    function automatic cmd_t mk(input logic [31:0] a, input logic [31:0] d, input logic we, input logic [2:0] op);
        cmd_t c;
        c.addr = a; c.wdata = d; c.we = we; c.op = op;
        return c;
    endfunction

    task automatic wait_idle(input int lim);
        int n;
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || bus.m0_req || bus.m1_req ||
                sb.size() > 0 || bus.busy) && n < lim) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", n < lim, 1'b1);
        @(negedge clk);
    endtask

    task automatic wait_gnt(input int m, input int lim, output int at);
        int n;
        n = 0; at = -1;
        while (n < lim && at < 0) begin
            @(negedge clk);
            if (m == 0 ? bus.m0_gnt : bus.m1_gnt) at = cyc;
            n++;
        end
        check("gnt_timeout", at >= 0, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n0, n1, bad;
        logic [31:0] v, old20;
        bit exp_order [4];

        for (int i = 0; i < 256; i++) begin
            v = $urandom; dm_mem[i] = v; ref_mem[i] = v;
        end
        dm_mem[4] = 32'h12345678; ref_mem[4] = 32'h12345678;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_busy",  bus.busy, 1'b0);
        check("rst_rvalid", {bus.m1_rvalid, bus.m0_rvalid}, 2'b00);
        check("rst_err",   {bus.m1_err, bus.m0_err}, 2'b00);
        check("rst_rdata", {bus.m1_rdata, bus.m0_rdata}, 64'd0);
        @(posedge clk); #1 rst = 0;

        // single load
        q0.push_back(mk(32'h10, 32'h0, 1'b0, 3'd2));
        wait_gnt(0, 20, n0);
        @(negedge clk); @(negedge clk);
        check("load_rvalid", bus.m0_rvalid, 1'b1);
        check("load_rdata",  bus.m0_rdata, 32'h12345678);
        check("load_err",    bus.m0_err, 1'b0);
        wait_idle(50);

        // misaligned store
        q1.push_back(mk(32'h13, 32'hCAFEF00D, 1'b1, 3'd2));
        wait_gnt(1, 20, n1);
        @(negedge clk);
        check("mis_dm_we", bus.dm_we, 1'b0);
        @(negedge clk);
        check("mis_rvalid", bus.m1_rvalid, 1'b1);
        check("mis_err",    bus.m1_err, 1'b1);
        wait_idle(50);
        check("mis_mem_unchanged", dm_mem[4], 32'h12345678);

        // simultaneous held requests
`ifdef MEM_ARBITER_RR_EN
        exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_order = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        gnt_log.delete();
        for (int i = 0; i < 4; i++) begin
            q0.push_back(mk($urandom_range(0, 255) << 2, $urandom, 1'b0, 3'd2));
            q1.push_back(mk($urandom_range(0, 255) << 2, $urandom, 1'b0, 3'd2));
        end
        wait_idle(200);
        check("order_len", gnt_log.size(), 8);
        for (int i = 0; i < 4; i++)
            if (gnt_log.size() > i) check($sformatf("order_%0d", i), gnt_log[i], exp_order[i]);

        // request raised while busy
        q0.push_back(mk(32'h44, 32'h0, 1'b0, 3'd2));
        wait_gnt(0, 20, n0);
        @(posedge clk); #1;
        q1.push_back(mk(32'h48, 32'h0, 1'b0, 3'd2));
        wait_gnt(1, 20, n1);
        check("busy_gnt_cycle", n1, n0 + 3);
        wait_idle(50);

        // reset during store ACCESS
        old20 = ref_mem[8];
        q0.push_back(mk(32'h20, 32'h5555AAAA, 1'b1, 3'd2));
        wait_gnt(0, 20, n0);
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        check("abort_busy", bus.busy, 1'b0);
        repeat (3) @(negedge clk);
        q1.push_back(mk(32'h20, 32'h0, 1'b0, 3'd2));
        wait_idle(50);
        check("abort_read_old", bus.m1_rdata, old20);
        check("abort_mem_old", dm_mem[8], old20);

        // back-to-back store then load
        q0.push_back(mk(32'h40, 32'hDEADBEEF, 1'b1, 3'd2));
        q0.push_back(mk(32'h40, 32'h0, 1'b0, 3'd2));
        wait_idle(50);
        check("b2b_rdata", bus.m0_rdata, 32'hDEADBEEF);

        // randomized traffic
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 1) == 1)
                q0.push_back(mk($urandom_range(0, 1023), $urandom, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7))));
            if ($urandom_range(0, 1) == 1)
                q1.push_back(mk($urandom_range(0, 1023), $urandom, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7))));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_idle(3000);

        bad = 0;
        for (int i = 0; i < 256; i++) if (dm_mem[i] !== ref_mem[i]) bad++;
        check("mem_final", bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end
endmodule
